hazard_stall_ctrl: RTL
======================

Name: hazard_stall_ctrl

Overview:
Central stall/flush controller for the 5-stage MIPS pipeline. It compares the register needs of the D-stage instruction against the pending writes in E and M. It also tracks a multi-cycle mult/div unit (MDU) busy window. From these it drives the enable inputs of the F/D/E/M pipeline registers and the clear input of the E register. It also keeps a saturating stall-cycle counter for performance debug.

Parameters:
MULT_CYC, 5, busy cycles after a mult/multu issue
DIV_CYC, 10, busy cycles after a div/divu issue
CNT_W, 4, MDU countdown width; must hold max(MULT_CYC, DIV_CYC)

Ports:
clk  input  1  pipeline clock
reset  input  1  asynchronous, active-high reset
D_rs  input  5  rs field of D-stage instruction
D_rt  input  5  rt field of D-stage instruction
D_Tuse_rs  input  2  cycles until D instr needs rs; 3 = not used
D_Tuse_rt  input  2  cycles until D instr needs rt; 3 = not used
D_is_md  input  1  D instr is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
E_A3  input  5  destination register of E-stage instr; 0 = none
E_Tnew  input  2  cycles until E result is forwardable
M_A3  input  5  destination register of M-stage instr; 0 = none
M_Tnew  input  2  cycles until M result is forwardable
E_start_mult  input  1  E-stage instr issues mult/multu this cycle
E_start_div  input  1  E-stage instr issues div/divu this cycle
F_EN  output  1  PC/F register enable
D_EN  output  1  D register enable
E_clr  output  1  synchronous clear (bubble insert) of E register
M_EN  output  1  M register enable
stall  output  1  stall asserted this cycle
md_busy  output  1  MDU busy this cycle
stall_cnt  output  32  saturating count of stall cycles

Behaviour:
- Register hazard (combinational):
  - stall_rs = D_rs!=0 and ((D_rs==E_A3 and D_Tuse_rs<E_Tnew) or (D_rs==M_A3 and D_Tuse_rs<M_Tnew)).
  - stall_rt is the same expression using D_rt and D_Tuse_rt.
  - Tuse=3 never stalls, because Tnew is at most 2 in E and at most 1 in M.
  - A destination register of 0 never matches.
- MDU countdown cnt[CNT_W-1:0]:
  - At a clock edge with E_start_div=1, cnt loads DIV_CYC.
  - Else, at an edge with E_start_mult=1, cnt loads MULT_CYC.
  - Else, if cnt!=0, cnt decrements.
  - Else cnt holds.
- md_busy = E_start_mult | E_start_div | (cnt!=0), combinational.
  - For a start in cycle t, md_busy is 1 for cycles t..t+N, where N is the loaded count.
  - A waiting md instruction in D advances in cycle t+N+1.
- Simultaneous mult and div start: div wins.
- A start while cnt!=0 reloads the counter; no accumulation.
- stall_md = D_is_md & md_busy.
- stall = stall_rs | stall_rt | stall_md.
- While stall=1: F_EN=0, D_EN=0, E_clr=1.
- While stall=0: F_EN=1, D_EN=1, E_clr=0.
- M_EN=1 always; it is retained as a port for future memory-wait stalls.
- Stalls are evaluated with the rising edge of the same cycle in mind; no added latency.
- stall_cnt:
  - Increments by 1 at each clock edge where stall=1.
  - Saturates at 32'hFFFF_FFFF and does not wrap.
- Reset:
  - Asserting reset asynchronously forces cnt=0 and stall_cnt=0.
  - While reset is high, outputs are forced to F_EN=1, D_EN=1, E_clr=0, M_EN=1, stall=0, md_busy=0, regardless of other inputs.
  - Deasserting reset mid-divide leaves no residual busy window.
- Unknown or garbage inputs in E/M after reset are neutralised by pipeline register reset, which zeroes A3.

Test Plan:
- Load-use: E_A3=8, E_Tnew=2, D_rs=8, D_Tuse_rs=1 -> stall=1, F_EN=0, D_EN=0, E_clr=1. Next cycle M_A3=8, M_Tnew=1, E_A3=0 -> stall=0.
- Register 0 and Tuse=3: E_A3=0, D_rs=0, E_Tnew=2 -> stall=0. Also D_rt=9, E_A3=9, D_Tuse_rt=3 -> stall=0.
- Div window: E_start_div=1 at cycle 0; D_is_md=1 throughout -> md_busy and stall high for cycles 0..10, low at cycle 11. stall_cnt reads 11.
- Mult reload: E_start_mult at cycle 0, then E_start_div at cycle 3 -> busy through cycle 13. Simultaneous mult and div start -> cnt=10.
- Async reset: assert reset between edges at cnt=6 -> md_busy=0 and stall_cnt=0 immediately, F_EN=1 without waiting for a clock edge.
- Saturation: preload stall_cnt to 32'hFFFF_FFFE via force, then hold stall for 3 cycles -> stall_cnt stays at 32'hFFFF_FFFF.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for the 5-stage MIPS pipeline.
// Detects Tuse/Tnew register hazards against E and M, tracks the mult/div
// busy window, drives pipeline register enables/clear and counts stall cycles.
module hazard_stall_ctrl #(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10,
    parameter int unsigned CNT_W    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_rs,
    input  logic [4:0]  D_rt,
    input  logic [1:0]  D_Tuse_rs,
    input  logic [1:0]  D_Tuse_rt,
    input  logic        D_is_md,
    input  logic [4:0]  E_A3,
    input  logic [1:0]  E_Tnew,
    input  logic [4:0]  M_A3,
    input  logic [1:0]  M_Tnew,
    input  logic        E_start_mult,
    input  logic        E_start_div,
    output logic        F_EN,
    output logic        D_EN,
    output logic        E_clr,
    output logic        M_EN,
    output logic        stall,
    output logic        md_busy,
    output logic [31:0] stall_cnt
);

    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_stall_cnt;

    logic w_stall_rs;
    logic w_stall_rt;
    logic w_md_busy;
    logic w_stall;

    // Register hazards: a D-stage source that needs its value before the
    // producer in E/M can forward it. Register 0 is never a real dependency.
    always_comb begin
        w_stall_rs = (D_rs != 5'd0) &&
                     (((D_rs == E_A3) && (D_Tuse_rs < E_Tnew)) ||
                      ((D_rs == M_A3) && (D_Tuse_rs < M_Tnew)));
        w_stall_rt = (D_rt != 5'd0) &&
                     (((D_rt == E_A3) && (D_Tuse_rt < E_Tnew)) ||
                      ((D_rt == M_A3) && (D_Tuse_rt < M_Tnew)));
    end

    // MDU busy covers the issue cycle plus the countdown window.
    always_comb begin
        w_md_busy = E_start_mult | E_start_div | (r_cnt != '0);
        w_stall   = w_stall_rs | w_stall_rt | (D_is_md & w_md_busy);
    end

    // Outputs; reset overrides every hazard so the pipeline flows freely.
    always_comb begin
        stall     = ~reset & w_stall;
        md_busy   = ~reset & w_md_busy;
        F_EN      = ~stall;
        D_EN      = ~stall;
        E_clr     = stall;
        M_EN      = 1'b1;
        stall_cnt = r_stall_cnt;
    end

    // MDU countdown: div load beats mult load; a new start reloads, never adds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (E_start_div) begin
            r_cnt <= CNT_W'(DIV_CYC);
        end else if (E_start_mult) begin
            r_cnt <= CNT_W'(MULT_CYC);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Saturating stall-cycle counter for performance debug.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

endmodule
